// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: EX/MEM register, flags register, data-memory req/ack FSM and MEM/WB register.
// Define MEM_TIMEOUT_EN to add the ack timeout counter and the sticky dmem_err flag.
module mem_stage_pipe #(
  parameter  int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned XLEN = 64,
  localparam int unsigned RW   = 5,
  localparam int unsigned CW   = 6,
  localparam int unsigned FW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_reg_data2,
  input  logic [XLEN-1:0] ex_bl_write_data,
  input  logic [RW-1:0]   ex_rd,
  input  logic [CW-1:0]   ex_control_out,
  input  logic [FW-1:0]   ex_flags,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic [FW-1:0]   current_flags,
  output logic [XLEN-1:0] ex_mem_forward_data,
  output logic [RW-1:0]   ex_mem_rd,
  output logic            ex_mem_reg_write,
  output logic [XLEN-1:0] mem_wb_forward_data,
  output logic [RW-1:0]   mem_wb_rd,
  output logic            mem_wb_reg_write,
  output logic            dmem_err
);

  localparam int unsigned CTL_REG_WRITE  = 5;
  localparam int unsigned CTL_MEM_WRITE  = 4;
  localparam int unsigned CTL_MEM_READ   = 3;
  localparam int unsigned CTL_MEM_TO_REG = 2;
  localparam int unsigned CTL_SET_FLAGS  = 1;
  localparam int unsigned CTL_BL         = 0;

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  logic [XLEN-1:0] exm_alu;
  logic [XLEN-1:0] exm_data2;
  logic [XLEN-1:0] exm_link;
  logic [RW-1:0]   exm_rd;
  logic            exm_reg_write;
  logic            exm_mem_write;
  logic            exm_mem_read;
  logic            exm_mem_to_reg;
  logic            exm_bl;

  state_t          state;
  state_t          state_nxt;
  logic            mem_op;
  logic            done;
  logic            timeout;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;

  // EX/MEM register and architectural flags; both freeze while memory stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exm_alu        <= '0;
      exm_data2      <= '0;
      exm_link       <= '0;
      exm_rd         <= '0;
      exm_reg_write  <= 1'b0;
      exm_mem_write  <= 1'b0;
      exm_mem_read   <= 1'b0;
      exm_mem_to_reg <= 1'b0;
      exm_bl         <= 1'b0;
      current_flags  <= '0;
    end else if (!mem_stall) begin
      exm_alu        <= ex_alu_result;
      exm_data2      <= ex_reg_data2;
      exm_link       <= ex_bl_write_data;
      exm_rd         <= ex_rd;
      exm_reg_write  <= ex_control_out[CTL_REG_WRITE];
      exm_mem_write  <= ex_control_out[CTL_MEM_WRITE];
      exm_mem_read   <= ex_control_out[CTL_MEM_READ];
      exm_mem_to_reg <= ex_control_out[CTL_MEM_TO_REG];
      exm_bl         <= ex_control_out[CTL_BL];
      if (ex_control_out[CTL_SET_FLAGS]) begin
        current_flags <= ex_flags;
      end
    end
  end

  assign mem_op              = exm_mem_write | exm_mem_read;
  assign ex_mem_forward_data = exm_bl ? exm_link : exm_alu;
  assign ex_mem_rd           = exm_rd;
  assign ex_mem_reg_write    = exm_reg_write;
  assign dmem_addr           = exm_alu;
  assign dmem_wdata          = exm_data2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op && !done) state_nxt = WAIT;
      WAIT:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An op completes on ack (or timeout) only while a request is outstanding
  always_comb begin
    dmem_req = 1'b0;
    case (state)
      IDLE:    dmem_req = mem_op;
      WAIT:    dmem_req = 1'b1;
      default: dmem_req = 1'b0;
    endcase
    done      = dmem_req & (dmem_ack | timeout);
    dmem_we   = dmem_req & exm_mem_write;
    mem_stall = dmem_req & ~done;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt;

  assign timeout = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      dmem_err <= 1'b0;
    end else begin
      if (state == WAIT && !done) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (timeout) begin
        dmem_err <= 1'b1;
      end
    end
  end
`else
  assign timeout  = 1'b0;
  assign dmem_err = 1'b0;
`endif

  // A timed-out load returns zero rather than whatever is on the bus
  assign load_data = timeout ? '0 : dmem_rdata;
  assign wb_data   = exm_mem_to_reg ? load_data : ex_mem_forward_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wb_forward_data <= '0;
      mem_wb_rd           <= '0;
      mem_wb_reg_write    <= 1'b0;
    end else if (mem_stall) begin
      mem_wb_forward_data <= '0;
      mem_wb_rd           <= '0;
      mem_wb_reg_write    <= 1'b0;
    end else begin
      mem_wb_forward_data <= wb_data;
      mem_wb_rd           <= exm_rd;
      mem_wb_reg_write    <= exm_reg_write;
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: write-backs are checked against a scoreboard queue,
// handshake/stall/flag behaviour against constants. Timeout steps run only with MEM_TIMEOUT_EN.
module tb_mem_stage_pipe;

  localparam logic [5:0] C_RW  = 6'b100000;
  localparam logic [5:0] C_MW  = 6'b010000;
  localparam logic [5:0] C_MR  = 6'b001000;
  localparam logic [5:0] C_M2R = 6'b000100;
  localparam logic [5:0] C_SF  = 6'b000010;
  localparam logic [5:0] C_BL  = 6'b000001;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_t;

  logic        clk;
  logic        reset;
  logic [63:0] ex_alu_result;
  logic [63:0] ex_reg_data2;
  logic [63:0] ex_bl_write_data;
  logic [4:0]  ex_rd;
  logic [5:0]  ex_control_out;
  logic [3:0]  ex_flags;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        mem_stall;
  logic [3:0]  current_flags;
  logic [63:0] ex_mem_forward_data;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write;
  logic [63:0] mem_wb_forward_data;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic        dmem_err;

  int  errors;
  int  checks;
  wb_t sb[$];

  mem_stage_pipe dut (
    .clk                 (clk),
    .reset               (reset),
    .ex_alu_result       (ex_alu_result),
    .ex_reg_data2        (ex_reg_data2),
    .ex_bl_write_data    (ex_bl_write_data),
    .ex_rd               (ex_rd),
    .ex_control_out      (ex_control_out),
    .ex_flags            (ex_flags),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_ack            (dmem_ack),
    .dmem_rdata          (dmem_rdata),
    .mem_stall           (mem_stall),
    .current_flags       (current_flags),
    .ex_mem_forward_data (ex_mem_forward_data),
    .ex_mem_rd           (ex_mem_rd),
    .ex_mem_reg_write    (ex_mem_reg_write),
    .mem_wb_forward_data (mem_wb_forward_data),
    .mem_wb_rd           (mem_wb_rd),
    .mem_wb_reg_write    (mem_wb_reg_write),
    .dmem_err            (dmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic [63:0] alu, input logic [63:0] d2, input logic [63:0] link,
                        input logic [4:0] rd, input logic [5:0] ctrl, input logic [3:0] flags);
    ex_alu_result    = alu;
    ex_reg_data2     = d2;
    ex_bl_write_data = link;
    ex_rd            = rd;
    ex_control_out   = ctrl;
    ex_flags         = flags;
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [63:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  // One clock; any write-back the DUT produces is popped from the scoreboard and compared
  task automatic tick();
    wb_t e;
    @(posedge clk);
    #2;
    if (mem_wb_reg_write === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 64'(mem_wb_rd), 64'd0);
        chk("wb_unexpected_en", 64'(mem_wb_reg_write), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", 64'(mem_wb_rd), 64'(e.rd));
        chk("wb_data", mem_wb_forward_data, e.data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    set_ex('0, '0, '0, '0, '0, '0);
    #1 reset = 1'b0;
    tick();
    tick();
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_stall", 64'(mem_stall), 64'd0);
    chk("rst_flags", 64'(current_flags), 64'd0);
    chk("rst_exm_fwd", ex_mem_forward_data, 64'd0);
    chk("rst_wb_en", 64'(mem_wb_reg_write), 64'd0);
    chk("rst_wb_data", mem_wb_forward_data, 64'd0);
    chk("rst_err", 64'(dmem_err), 64'd0);
    reset = 1'b1;

    // ADDS X1 = 5 - 7 with SetFlags
    set_ex(64'hFFFF_FFFF_FFFF_FFFE, '0, '0, 5'd1, C_RW | C_SF, 4'b1000);
    push_wb(5'd1, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    chk("adds_flags", 64'(current_flags), 64'h8);
    chk("adds_exm_fwd", ex_mem_forward_data, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("adds_exm_rd", 64'(ex_mem_rd), 64'd1);
    chk("adds_exm_rw", 64'(ex_mem_reg_write), 64'd1);
    set_ex('0, '0, '0, '0, '0, 4'b0101);
    tick();
    chk("noset_flags", 64'(current_flags), 64'h8);

    // LDUR with ack after three stall cycles; SetFlags waits in EX meanwhile
    set_ex(64'h40, '0, '0, 5'd2, C_RW | C_MR | C_M2R, '0);
    push_wb(5'd2, 64'hDEAD);
    tick();
    set_ex('0, '0, '0, '0, C_SF, 4'b0001);
    #1;
    chk("ld_issue_req", 64'(dmem_req), 64'd1);
    chk("ld_issue_we", 64'(dmem_we), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall", 64'(mem_stall), 64'd1);
      chk("ld_addr", dmem_addr, 64'h40);
      tick();
      chk("ld_bubble_en", 64'(mem_wb_reg_write), 64'd0);
      chk("ld_bubble_data", mem_wb_forward_data, 64'd0);
      chk("ld_flags_hold", 64'(current_flags), 64'h8);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 64'hDEAD;
    #1;
    chk("ld_ack_stall", 64'(mem_stall), 64'd0);
    chk("ld_ack_req", 64'(dmem_req), 64'd1);
    tick();
    chk("ld_wb_seen", 64'(sb.size()), 64'd0);
    chk("flags_after_stall", 64'(current_flags), 64'h1);
    dmem_ack = 1'b0;
    set_ex('0, '0, '0, '0, '0, '0);
    #1;
    chk("ld_done_req", 64'(dmem_req), 64'd0);

    // STUR with zero-wait ack
    set_ex(64'h80, 64'h1234, '0, '0, C_MW, '0);
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("st_req", 64'(dmem_req), 64'd1);
    chk("st_we", 64'(dmem_we), 64'd1);
    chk("st_addr", dmem_addr, 64'h80);
    chk("st_wdata", dmem_wdata, 64'h1234);
    chk("st_stall", 64'(mem_stall), 64'd0);
    set_ex('0, '0, '0, '0, '0, '0);
    tick();
    #1;
    chk("st_stray_ack_req", 64'(dmem_req), 64'd0);
    chk("st_we_once", 64'(dmem_we), 64'd0);
    chk("st_stray_ack_stall", 64'(mem_stall), 64'd0);
    chk("st_no_wb", 64'(mem_wb_reg_write), 64'd0);
    dmem_ack = 1'b0;

    // BL: link value forwarded, write-back to X30
    set_ex(64'hAAAA, '0, 64'h104, 5'd30, C_RW | C_BL, '0);
    push_wb(5'd30, 64'h104);
    tick();
    chk("bl_exm_fwd", ex_mem_forward_data, 64'h104);
    chk("bl_exm_rd", 64'(ex_mem_rd), 64'd30);
    set_ex('0, '0, '0, '0, '0, '0);
    tick();

    // Back-to-back loads: one wait cycle, then zero-wait
    set_ex(64'h100, '0, '0, 5'd3, C_RW | C_MR | C_M2R, '0);
    push_wb(5'd3, 64'h111);
    tick();
    set_ex(64'h108, '0, '0, 5'd4, C_RW | C_MR | C_M2R, '0);
    push_wb(5'd4, 64'h222);
    #1;
    chk("b2b_first_addr", dmem_addr, 64'h100);
    chk("b2b_first_stall", 64'(mem_stall), 64'd1);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 64'h111;
    #1;
    chk("b2b_first_ack_stall", 64'(mem_stall), 64'd0);
    tick();
    set_ex('0, '0, '0, '0, '0, '0);
    dmem_rdata = 64'h222;
    #1;
    chk("b2b_second_req", 64'(dmem_req), 64'd1);
    chk("b2b_second_addr", dmem_addr, 64'h108);
    chk("b2b_second_stall", 64'(mem_stall), 64'd0);
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("b2b_served_once", 64'(dmem_req), 64'd0);

    // Reset during WAIT abandons the request
    set_ex(64'h200, '0, '0, 5'd5, C_RW | C_MR | C_M2R, '0);
    tick();
    set_ex('0, '0, '0, '0, '0, '0);
    tick();
    #1;
    chk("wait_req", 64'(dmem_req), 64'd1);
    reset = 1'b0;
    #1;
    chk("arst_req", 64'(dmem_req), 64'd0);
    chk("arst_stall", 64'(mem_stall), 64'd0);
    chk("arst_addr", dmem_addr, 64'd0);
    chk("arst_exm_fwd", ex_mem_forward_data, 64'd0);
    chk("arst_exm_rw", 64'(ex_mem_reg_write), 64'd0);
    chk("arst_flags", 64'(current_flags), 64'd0);
    chk("arst_wb_en", 64'(mem_wb_reg_write), 64'd0);
    tick();
    reset = 1'b1;
    set_ex(64'h55, '0, '0, 5'd6, C_RW, '0);
    push_wb(5'd6, 64'h55);
    tick();
    set_ex(64'h300, '0, '0, 5'd7, C_RW | C_MR | C_M2R, '0);
    push_wb(5'd7, 64'h77);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 64'h77;
    #1;
    chk("post_rst_addr", dmem_addr, 64'h300);
    set_ex('0, '0, '0, '0, '0, '0);
    tick();
    dmem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // No ack: forced completion after the timeout with zero load data
    set_ex(64'h400, '0, '0, 5'd8, C_RW | C_MR | C_M2R, '0);
    push_wb(5'd8, 64'd0);
    tick();
    set_ex('0, '0, '0, '0, '0, '0);
    dmem_rdata = 64'hBAD;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_stall", 64'(mem_stall), 64'd1);
      chk("to_err_clear", 64'(dmem_err), 64'd0);
      tick();
    end
    #1;
    chk("to_force_stall", 64'(mem_stall), 64'd0);
    tick();
    chk("to_err_set", 64'(dmem_err), 64'd1);
    tick();
    tick();
    tick();
    chk("to_err_sticky", 64'(dmem_err), 64'd1);
    reset = 1'b0;
    #1;
    chk("to_err_rst", 64'(dmem_err), 64'd0);
    reset = 1'b1;
`else
    chk("err_tied_low", 64'(dmem_err), 64'd0);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
